ifetch: RTL and testbench

Instruction-fetch stage of the pipelined core: owns the architectural fetch PC, drives the instruction bus (`ireq`/`iresp`), and delivers `{pc, instr}` pairs to decode through a 2-entry buffer with a valid/ready handshake. It sits directly upstream of decode and is the core's sole instruction-bus master. It accepts PC redirects from execute (branch/jump resolution) and discards wrong-path fetches, including a bus transaction already in flight.

---
 rtl/common.sv | 35 +++
 rtl/fetch_buf.sv | 55 +++++
 rtl/ifetch.sv | 153 +++++++++++++++
 tb/tb_ifetch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// common: types and constants shared by the fetch stage and its neighbours.
// ifetch optionally checks redirect alignment when IFETCH_MISALIGN_CHECK_EN is defined.
package common;

    localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } ifetch_state_t;

    // Sequential fetch address; wraps modulo 2^64.
    function automatic logic [63:0] next_pc(input logic [63:0] cur);
        return cur + 64'd4;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of fetch entries between the bus and decode.
// Slot 0 is always the head, so the head output comes straight from a register.
module fetch_buf
    import common::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         enq,
    input  fetch_entry_t enq_entry,
    input  logic         deq,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t ent0;
    fetch_entry_t ent1;

    assign head = ent0;

    // Storage and occupancy; flush beats any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= '0;
        end else begin
            case ({enq, deq})
                2'b10: begin
                    if (count == 2'd0) begin
                        ent0 <= enq_entry;
                    end else begin
                        ent1 <= enq_entry;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    ent1  <= '0;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= enq_entry;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= enq_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage. Owns the fetch PC, masters the instruction
// bus with at most one transaction outstanding, and feeds decode through a
// 2-entry buffer. Redirects flush the buffer and abandon wrong-path fetches.
// Optional: IFETCH_MISALIGN_CHECK_EN turns misaligned redirect targets into a
// single misalign-flagged entry instead of a bus fetch.
module ifetch
    import common::*;
#(
    parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    output ibus_req_t    ireq,
    input  ibus_resp_t   iresp,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output fetch_entry_t out_entry
);

    ifetch_state_t state;
    logic [63:0]   pc;
    logic [63:0]   drop_addr;
    logic [63:0]   target;
    logic [1:0]    count;
    logic [1:0]    occ;
    logic          deq;
    logic          space;
    logic          room_after;
    logic          bus_done;
    logic          redir_mis;
    logic          mis_hold;
    logic          enq;
    fetch_entry_t  enq_entry;
    logic          unused_bits;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic mis_pend;
    logic parked;

    assign target      = redirect_pc;
    assign redir_mis   = (redirect_pc[1:0] != 2'b00);
    assign mis_hold    = mis_pend | parked;
    assign unused_bits = iresp.addr_ok;
`else
    assign target      = {redirect_pc[63:2], 2'b00};
    assign redir_mis   = 1'b0;
    assign mis_hold    = 1'b0;
    assign unused_bits = iresp.addr_ok ^ (^redirect_pc[1:0]);
`endif

    assign out_valid  = (count != 2'd0);
    assign deq        = out_valid & out_ready;
    assign occ        = count - {1'b0, deq};
    assign space      = (occ != 2'd2);
    assign room_after = (occ == 2'd0);
    assign bus_done   = (state == REQ) && iresp.data_ok;

    // The address is held on the abandoned target while a wrong-path fetch drains.
    assign ireq = '{valid: (state != IDLE), addr: ((state == DROP) ? drop_addr : pc)};

    // Select what, if anything, enters the buffer this cycle.
    always_comb begin
        enq       = 1'b0;
        enq_entry = '0;
        if (!redirect_valid && bus_done) begin
            enq       = 1'b1;
            enq_entry = '{pc: pc, instr: iresp.data, misalign: 1'b0};
        end
`ifdef IFETCH_MISALIGN_CHECK_EN
        else if (!redirect_valid && (state == IDLE) && mis_pend && space) begin
            enq       = 1'b1;
            enq_entry = '{pc: pc, instr: 32'h0, misalign: 1'b1};
        end
`endif
    end

    // Fetch FSM and PC; a redirect takes priority over all normal progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= PC_RESET;
            drop_addr <= '0;
        end else if (redirect_valid) begin
            pc <= target;
            case (state)
                REQ: begin
                    if (iresp.data_ok) begin
                        state <= redir_mis ? IDLE : REQ;
                    end else begin
                        state     <= DROP;
                        drop_addr <= pc;
                    end
                end
                DROP: begin
                    if (iresp.data_ok) begin
                        state <= redir_mis ? IDLE : REQ;
                    end
                end
                default: state <= redir_mis ? IDLE : REQ;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (space && !mis_hold) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (iresp.data_ok) begin
                        pc    <= next_pc(pc);
                        state <= room_after ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (iresp.data_ok) begin
                        state <= mis_hold ? IDLE : REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    // Misaligned target: wait for buffer space, emit one flagged entry, then park.
    always_ff @(posedge clk) begin
        if (reset) begin
            mis_pend <= 1'b0;
            parked   <= 1'b0;
        end else if (redirect_valid) begin
            mis_pend <= redir_mis;
            parked   <= 1'b0;
        end else if ((state == IDLE) && mis_pend && space) begin
            mis_pend <= 1'b0;
            parked   <= 1'b1;
        end
    end
`endif

    fetch_buf u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .enq       (enq),
        .enq_entry (enq_entry),
        .deq       (deq),
        .head      (out_entry),
        .count     (count)
    );

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: bus model with programmable latency, expected-output queue,
// a table of redirect vectors and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_ifetch;
    import common::*;

    logic         clk = 1'b0;
    logic         reset;
    ibus_req_t    ireq;
    ibus_resp_t   iresp;
    logic         redirect_valid;
    logic [63:0]  redirect_pc;
    logic         out_valid;
    logic         out_ready;
    fetch_entry_t out_entry;

    always #5 clk = ~clk;

    ifetch #(.PC_RESET(64'h8000_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ireq           (ireq),
        .iresp          (iresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_entry      (out_entry)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           bus_lat  = 1;
    int           wait_cnt = 0;
    bit           in_flight = 1'b0;
    logic [63:0]  fl_addr  = '0;
    fetch_entry_t exp_q[$];
    logic [63:0]  req_log[$];
    int           deliv_cyc[$];

    typedef struct {
        logic [63:0] target;
        int          lat;
        int          n;
        logic [63:0] base;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [31:0] ifn(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic void check(input bit ok, input string nm,
                                  input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic logic [63:0] req_at(input int i);
        return (req_log.size() > i) ? req_log[i] : '1;
    endfunction

    function automatic void push_exp(input logic [63:0] base, input int n);
        logic [63:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: a, instr: ifn(a), misalign: 1'b0});
            a = a + 64'd4;
        end
    endfunction

    // One clock: drive bus response, score any handshake, advance past the edge.
    task automatic step();
        fetch_entry_t e;
        if (ireq.valid) begin
            if (!in_flight) begin
                in_flight = 1'b1;
                fl_addr   = ireq.addr;
                wait_cnt  = 0;
                req_log.push_back(ireq.addr);
            end else begin
                check(ireq.addr == fl_addr, "addr_stable", 128'(ireq.addr), 128'(fl_addr));
            end
            iresp.data_ok = (wait_cnt >= bus_lat);
            iresp.data    = iresp.data_ok ? ifn(fl_addr) : 32'hDEAD_BEEF;
        end else begin
            if (in_flight) check(ireq.valid, "valid_held", 128'(ireq.valid), 128'(1));
            iresp.data_ok = 1'b0;
            iresp.data    = '0;
        end
        iresp.addr_ok = ireq.valid;
        if (redirect_valid) begin
            exp_q.delete();
        end else if (out_valid && out_ready) begin
            check(exp_q.size() != 0, "out_expected", 128'(out_entry.pc), 128'(0));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(out_entry == e, "out_entry", 128'(out_entry), 128'(e));
                deliv_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (in_flight) begin
            if (iresp.data_ok) in_flight = 1'b0;
            else wait_cnt++;
        end
    endtask

    task automatic drain(input int budget, input string nm);
        int c;
        c = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && c < budget) begin
            step();
            c++;
        end
        out_ready = 1'b0;
        check(exp_q.size() == 0, nm, 128'(exp_q.size()), 128'(0));
    endtask

    task automatic redirect(input logic [63:0] t);
        redirect_pc    = t;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        iresp          = '0;
        repeat (2) @(posedge clk);
        #1;
        check(ireq.valid == 1'b0, "reset_ireq_valid", 128'(ireq.valid), 128'(0));
        check(out_valid == 1'b0, "reset_out_valid", 128'(out_valid), 128'(0));
        check(out_entry == '0, "reset_out_entry", 128'(out_entry), 128'(0));
        in_flight = 1'b0;
        exp_q.delete();
        req_log.delete();
        deliv_cyc.delete();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int hits;

        vecs.push_back('{target: 64'h8000_4000, lat: 0, n: 4, base: 64'h8000_4000});
        vecs.push_back('{target: 64'h8000_5000, lat: 2, n: 3, base: 64'h8000_5000});
        vecs.push_back('{target: 64'hFFFF_FFFF_FFFF_FFF8, lat: 0, n: 3, base: 64'hFFFF_FFFF_FFFF_FFF8});
        vecs.push_back('{target: 64'h0000_0000_0000_1000, lat: 1, n: 2, base: 64'h0000_0000_0000_1000});
`ifndef IFETCH_MISALIGN_CHECK_EN
        vecs.push_back('{target: 64'h8000_6002, lat: 0, n: 2, base: 64'h8000_6000});
`endif

        // Basic fetch, data_ok one cycle after valid: one entry every 2 cycles.
        do_reset();
        bus_lat = 1;
        c0 = cyc;
        check(ireq.valid == 1'b0, "t1_no_req_first", 128'(ireq.valid), 128'(0));
        step();
        check(ireq.valid && ireq.addr == 64'h8000_0000, "t1_first_req", 128'(ireq.addr), 128'(64'h8000_0000));
        push_exp(64'h8000_0000, 3);
        drain(40, "t1_drain");
        check(deliv_cyc.size() == 3, "t1_n_deliv", 128'(deliv_cyc.size()), 128'(3));
        if (deliv_cyc.size() == 3) begin
            check(deliv_cyc[0] == c0 + 3, "t1_cyc0", 128'(deliv_cyc[0]), 128'(c0 + 3));
            check(deliv_cyc[1] == c0 + 5, "t1_cyc1", 128'(deliv_cyc[1]), 128'(c0 + 5));
            check(deliv_cyc[2] == c0 + 7, "t1_cyc2", 128'(deliv_cyc[2]), 128'(c0 + 7));
        end

        // Decode stalled: buffer fills at 2, bus goes quiet, resumes on release.
        do_reset();
        bus_lat = 1;
        repeat (10) step();
        check(req_log.size() == 2, "t2_req_count", 128'(req_log.size()), 128'(2));
        check(ireq.valid == 1'b0, "t2_bus_idle", 128'(ireq.valid), 128'(0));
        check(out_valid == 1'b1, "t2_out_valid", 128'(out_valid), 128'(1));
        check(out_entry.pc == 64'h8000_0000, "t2_head_pc", 128'(out_entry.pc), 128'(64'h8000_0000));
        push_exp(64'h8000_0000, 3);
        drain(40, "t2_drain");
        check(req_at(2) == 64'h8000_0008, "t2_resume_addr", 128'(req_at(2)), 128'(64'h8000_0008));

        // Redirect while 0x8000_0004 is in flight; response arrives 3 cycles later.
        do_reset();
        bus_lat = 4;
        push_exp(64'h8000_0000, 1);
        drain(30, "t3_first");
        redirect(64'h8000_1000);
        for (int i = 0; i < 10 && in_flight; i++) begin
            check(ireq.valid && ireq.addr == 64'h8000_0004, "t3_hold_addr", 128'(ireq.addr), 128'(64'h8000_0004));
            step();
        end
        check(!in_flight, "t3_drop_done", 128'(in_flight), 128'(0));
        check(ireq.valid && ireq.addr == 64'h8000_1000, "t3_new_req", 128'(ireq.addr), 128'(64'h8000_1000));
        push_exp(64'h8000_1000, 1);
        drain(30, "t3_drain");
        check(req_at(2) == 64'h8000_1000, "t3_req_log", 128'(req_at(2)), 128'(64'h8000_1000));

        // Back-to-back at zero latency, then redirect with data_ok and dequeue together.
        do_reset();
        bus_lat = 0;
        push_exp(64'h8000_0000, 3);
        drain(20, "t4_drain");
        if (deliv_cyc.size() == 3) begin
            check(deliv_cyc[1] - deliv_cyc[0] == 1, "t4_rate0", 128'(deliv_cyc[1] - deliv_cyc[0]), 128'(1));
            check(deliv_cyc[2] - deliv_cyc[1] == 1, "t4_rate1", 128'(deliv_cyc[2] - deliv_cyc[1]), 128'(1));
        end
        out_ready = 1'b1;
        check(out_valid == 1'b1, "t4_pre_out_valid", 128'(out_valid), 128'(1));
        check(ireq.valid == 1'b1, "t4_pre_req", 128'(ireq.valid), 128'(1));
        redirect(64'h8000_2000);
        check(out_valid == 1'b0, "t4_flushed", 128'(out_valid), 128'(0));
        check(ireq.valid && ireq.addr == 64'h8000_2000, "t4_new_req", 128'(ireq.addr), 128'(64'h8000_2000));
        push_exp(64'h8000_2000, 2);
        drain(20, "t4_after");

        // Two redirects while draining a wrong-path fetch: only the latest is fetched.
        do_reset();
        bus_lat = 6;
        out_ready = 1'b1;
        step();
        step();
        redirect(64'h8000_0100);
        redirect(64'h8000_0200);
        push_exp(64'h8000_0200, 1);
        drain(40, "t5_drain");
        check(req_at(1) == 64'h8000_0200, "t5_second_req", 128'(req_at(1)), 128'(64'h8000_0200));
        hits = 0;
        foreach (req_log[i]) if (req_log[i] == 64'h8000_0100) hits++;
        check(hits == 0, "t5_no_0x100", 128'(hits), 128'(0));

        // Vector table: redirect from whatever state the previous row left behind.
        out_ready = 1'b0;
        foreach (vecs[k]) begin
            bus_lat = vecs[k].lat;
            redirect(vecs[k].target);
            push_exp(vecs[k].base, vecs[k].n);
            drain(100, "vec_drain");
        end

`ifdef IFETCH_MISALIGN_CHECK_EN
        // Misaligned redirect: one flagged entry, no bus traffic, then parked.
        do_reset();
        bus_lat = 1;
        redirect(64'h8000_0002);
        exp_q.push_back('{pc: 64'h8000_0002, instr: 32'h0, misalign: 1'b1});
        drain(20, "t7_drain");
        repeat (5) begin
            check(ireq.valid == 1'b0, "t7_no_req", 128'(ireq.valid), 128'(0));
            step();
        end
        check(req_log.size() == 0, "t7_req_log", 128'(req_log.size()), 128'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
